// File: rtl/hatch_imem.sv
// Instruction memory for the CPU hatch fetch port, filled by a byte-stream loader.
// Eight byte-wide banks serve one 48-bit big-endian fetch per cycle at any byte alignment.
module hatch_imem #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter logic [47:0] NOP_WORD    = 48'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hatch_address,
  output logic [47:0] hatch_instruction,
  input  logic        load_start,
  input  logic [31:0] load_addr,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        load_error
);

  // state | meaning
  // IDLE  | no load in progress; loader bytes ignored, CPU released
  // LOAD  | accepting one byte per cycle at ptr until load_last

  localparam int unsigned ROWS  = DEPTH_BYTES / 8;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [32:0] DEPTH33 = 33'(DEPTH_BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [32:0] ptr;
  logic        wr_en, wr_go, err_set, ptr_adv, ptr_load;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    wr_en      = 1'b0;
    err_set    = 1'b0;
    ptr_adv    = 1'b0;
    ptr_load   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          ptr_load  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ptr_adv = 1'b1;
          if (ptr < DEPTH33) wr_en   = 1'b1;
          else               err_set = 1'b1;
          if (load_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A write coinciding with reset is dropped so a reset mid-load leaves only completed bytes.
  assign wr_go = wr_en & ~rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ptr_load)     ptr <= {1'b0, load_addr};
      else if (ptr_adv) ptr <= ptr + 33'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           load_error <= 1'b0;
    else if (ptr_load) load_error <= 1'b0;
    else if (err_set)  load_error <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cpu_hold <= 1'b1;
    else     cpu_hold <= (state_nxt == LOAD);
  end

  logic [2:0]       fa_lo;
  logic [ROW_W-1:0] fa_row;
  logic [7:0]       rd_byte [8];

  assign fa_lo  = hatch_address[2:0];
  assign fa_row = hatch_address[ROW_W+2:3];

  for (genvar b = 0; b < 8; b++) begin : g_bank
    localparam logic [2:0] BANK = 3'(b);
    logic [7:0]       mem [ROWS];
    logic [ROW_W-1:0] rd_row;

    // Banks below the start bank hold the bytes that spill into the next row.
    assign rd_row = fa_row + ROW_W'(BANK < fa_lo);

    always_ff @(posedge clk) begin
      if (wr_go && (ptr[2:0] == BANK)) mem[ptr[ROW_W+2:3]] <= load_data;
    end

    assign rd_byte[b] = mem[rd_row];
  end

  logic [47:0] fetch_word;
  logic [2:0]  sel;
  logic        in_range;

  always_comb begin
    fetch_word = '0;
    sel        = '0;
    for (int i = 0; i < 6; i++) begin
      sel = fa_lo + 3'(i);
      fetch_word[47-8*i -: 8] = rd_byte[sel];
    end
  end

  assign in_range = (({1'b0, hatch_address} + 33'd5) < DEPTH33);

  always_ff @(posedge clk) begin
    if (rst)           hatch_instruction <= NOP_WORD;
    else if (in_range) hatch_instruction <= fetch_word;
    else               hatch_instruction <= NOP_WORD;
  end

endmodule

// File: doc/hatch_imem.md
# hatch_imem

Instruction memory that serves the CPU's hatch fetch port. It returns the 48-bit instruction at the byte address the CPU presents on `hatch_address`. A byte-stream loader port fills it, and `cpu_hold` keeps the CPU stalled while a load is in progress. It sits between the CPU and the host/loader and replaces the stimulus-driven instruction source used in simulation.

## Interface

Parameters:
- `DEPTH_BYTES`, default 4096: memory size in bytes; power of two, at least 8.
- `NOP_WORD`, default 48'h0: value returned for out-of-range fetches and after reset.

Ports:
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `hatch_address`  in  32: byte address of the instruction being fetched.
- `hatch_instruction`  out  48: registered instruction word, big-endian.
- `load_start`  in  1: pulse that begins a load at `load_addr`.
- `load_addr`  in  32: start byte address, sampled when `load_start` is accepted.
- `load_valid`  in  1: `load_data` is valid this cycle.
- `load_data`  in  8: byte to write.
- `load_last`  in  1: marks the final byte of the load; qualified by `load_valid`.
- `load_ready`  out  1: the loader accepts a byte this cycle.
- `cpu_hold`  out  1: CPU must stall/stay in reset.
- `load_error`  out  1: sticky flag; at least one byte of the current load was out of range.

## Operation

- Storage is 8 byte-wide banks, each DEPTH_BYTES/8 entries. Byte address `a` is stored at bank `a[2:0]`, row `a>>3`. Memory contents are not cleared by reset.
- Fetch path, every cycle:
  - Let `a` = `hatch_address`.
  - If `a + 5 < DEPTH_BYTES`, with the sum computed in 33 bits, `hatch_instruction` <= {B[a], B[a+1], B[a+2], B[a+3], B[a+4], B[a+5]}. B[a] is the MSB byte and holds the opcode. B[a+1] is the pad byte. B[a+2..a+5] is the 32-bit immediate, MSB first.
  - Otherwise `hatch_instruction` <= NOP_WORD.
  - Any alignment is legal: 6-byte strides, odd addresses, and bank wrap across a row boundary.
- Loader state machine, states IDLE and LOAD:
  - IDLE: `load_ready`=0. When `load_start`=1: ptr <= `load_addr`, `load_error` <= 0, go to LOAD.
  - LOAD: `load_ready`=1.
    - On `load_valid`: if ptr < DEPTH_BYTES, write `load_data` to B[ptr]; otherwise drop the byte and set `load_error`=1. Then ptr <= ptr+1, using 33-bit arithmetic with no wrap.
    - If `load_valid` & `load_last`: go to IDLE in the same cycle as that final write.
    - `load_start` is ignored while in LOAD.
  - In IDLE, `load_valid` is ignored.
- `cpu_hold` is registered: 1 while `rst` is high and for every cycle the state is LOAD, 0 in IDLE.
- A fetch and a write to the same byte in the same cycle returns the old byte. The new byte is visible from the next fetch cycle.

## Timing

- Reset values, on the edge where `rst`=1: state=IDLE, `hatch_instruction`=NOP_WORD, `load_ready`=0, `load_error`=0, `cpu_hold`=1. ptr is don't-care.
- First edge with `rst`=0 and no `load_start`: `cpu_hold`=0.
- Fetch latency is 1 cycle. `hatch_address` sampled at edge k appears on `hatch_instruction` after edge k.
- `load_start` at edge k: `load_ready` and `cpu_hold` are 1 after edge k.
- Load throughput is one byte per cycle. Gaps in `load_valid` are allowed and stall the pointer.
- Final byte (`load_last`) at edge m: `load_ready`=0 and `cpu_hold`=0 after edge m. A fetch sampled at edge m+1 sees the final byte.
- Reset during LOAD: return to IDLE and clear `load_error`. Bytes already written are retained; the partial load is not rolled back.
- `load_error` holds its value until the next accepted `load_start` or `rst`.

## Test plan

- Load 18 bytes at `load_addr`=0: 01 00 13 37 D0 0D, 01 00 CA FE BA BE, 05 00 00 00 00 00, with `load_last` on the 18th byte. Then fetch 0, 6, 12 -> 48'h01001337D00D, 48'h0100CAFEBABE, 48'h050000000000, each 1 cycle after its address. `cpu_hold` is 1 exactly from the cycle after `load_start` through the `load_last` cycle.
- Fetch unaligned addresses 3 and 5, crossing the bank-7 to bank-0 row boundary -> 48'h37D00D0100CA and 48'h0D0100CAFEBA.
- Boundaries: fetch DEPTH_BYTES-6 -> the stored bytes. Fetch DEPTH_BYTES-5 -> NOP_WORD. Fetch 32'hFFFFFFFE -> NOP_WORD, with no wrap.
- Overrun: `load_addr`=DEPTH_BYTES-2, send 4 bytes AA BB CC DD with last on DD -> B[DEPTH-2]=AA and B[DEPTH-1]=BB. `load_error`=1 after the CC cycle and stays 1 until the next `load_start`.
- `load_valid` gaps (1,0,0,1,1) plus a `load_start` pulse issued mid-load -> the 3 bytes land at consecutive addresses and the ptr is not re-based.
- Assert `rst` after 3 of 6 bytes -> next cycle: IDLE, `load_ready`=0, `cpu_hold`=1 while `rst` is held, `hatch_instruction`=NOP_WORD. After release, the 3 written bytes read back intact and later bytes are unchanged.
